// File: rtl/fifomult_param_if.sv
// rtl/fifomult_param_if.sv - operand/result bus for fifomult_param
interface fifomult_param_if #(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4
);
    logic                              data_in_valid;
    logic [DATA_W-1:0]                 data_in;
    logic                              data_in_parity;
    logic                              signed_mode;
    logic                              data_out_ready;
    logic                              busy_out;
    logic [2*DATA_W-1:0]               data_out;
    logic                              data_out_parity;
    logic                              data_out_valid;
    logic                              data_in_parity_error;
    logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count;

    modport master (
        output data_in_valid, data_in, data_in_parity, signed_mode, data_out_ready,
        input  busy_out, data_out, data_out_parity, data_out_valid,
               data_in_parity_error, fifo_count
    );

    modport slave (
        input  data_in_valid, data_in, data_in_parity, signed_mode, data_out_ready,
        output busy_out, data_out, data_out_parity, data_out_valid,
               data_in_parity_error, fifo_count
    );
endinterface

// File: rtl/fifomult_param.sv
// rtl/fifomult_param.sv - parity-checked operand-pair collector, product FIFO and output register
module fifomult_param #(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    fifomult_param_if.slave    bus
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH+1);
    localparam int PRD_W = 2*DATA_W;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    localparam logic [0:0] WAIT_A = 1'b0;
    localparam logic [0:0] WAIT_B = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic              a_ok_q, a_ok_d;
    logic              sgn_q, sgn_d;
    logic              perr_q, perr_d;

    logic [PRD_W-1:0]  mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic [PRD_W-1:0]  out_q, out_d;
    logic              out_par_q, out_par_d;
    logic              out_vld_q, out_vld_d;

    logic              busy;
    logic              sample;
    logic              word_ok;
    logic              push;
    logic              pop;
    logic [PRD_W-1:0]  a_ext, b_ext, product;

    assign busy    = (count_q == FULL_CNT);
    assign sample  = bus.data_in_valid && !busy;
    assign word_ok = ((^bus.data_in) == bus.data_in_parity);

    // Sign- or zero-extend to full width; the low 2*DATA_W bits of the product are exact either way.
    assign a_ext   = {{DATA_W{sgn_q & a_q[DATA_W-1]}}, a_q};
    assign b_ext   = {{DATA_W{sgn_q & bus.data_in[DATA_W-1]}}, bus.data_in};
    assign product = a_ext * b_ext;

    assign push = sample && (state_q == WAIT_B) && a_ok_q && word_ok;
    assign pop  = (count_q != '0) && (!out_vld_q || bus.data_out_ready);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        a_ok_d  = a_ok_q;
        sgn_d   = sgn_q;
        perr_d  = 1'b0;
        if (sample) begin
            if (state_q == WAIT_A) begin
                a_d     = bus.data_in;
                a_ok_d  = word_ok;
                sgn_d   = bus.signed_mode;
                state_d = WAIT_B;
            end else begin
                perr_d  = !(a_ok_q && word_ok);
                state_d = WAIT_A;
            end
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + {{(CNT_W-1){1'b0}}, push} - {{(CNT_W-1){1'b0}}, pop};
        if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    always_comb begin
        out_d     = out_q;
        out_par_d = out_par_q;
        out_vld_d = out_vld_q;
        if (pop) begin
            out_d     = mem_q[rd_ptr_q];
            out_par_d = ^mem_q[rd_ptr_q];
            out_vld_d = 1'b1;
        end else if (out_vld_q && bus.data_out_ready) begin
            out_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= WAIT_A;
            a_q       <= '0;
            a_ok_q    <= 1'b0;
            sgn_q     <= 1'b0;
            perr_q    <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            out_q     <= '0;
            out_par_q <= 1'b0;
            out_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            a_ok_q    <= a_ok_d;
            sgn_q     <= sgn_d;
            perr_q    <= perr_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            out_q     <= out_d;
            out_par_q <= out_par_d;
            out_vld_q <= out_vld_d;
        end
    end

    // Storage needs no reset: the count gates every read.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= product;
    end

    assign bus.busy_out             = busy;
    assign bus.data_out             = out_q;
    assign bus.data_out_parity      = out_par_q;
    assign bus.data_out_valid       = out_vld_q;
    assign bus.data_in_parity_error = perr_q;
    assign bus.fifo_count           = count_q;
endmodule

// File: tb/tb_fifomult_param.sv
// tb/tb_fifomult_param.sv - directed self-checking bench for fifomult_param
module tb_fifomult_param;
    logic clk = 1'b0;
    logic rst;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    fifomult_param_if #(.DATA_W(16), .FIFO_DEPTH(4)) bus ();

    fifomult_param #(.DATA_W(16), .FIFO_DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [15:0] w, input logic bad, input logic sg);
        bus.data_in        = w;
        bus.data_in_parity = (^w) ^ bad;
        bus.signed_mode    = sg;
        bus.data_in_valid  = 1'b1;
        @(negedge clk);
        bus.data_in_valid  = 1'b0;
    endtask

    task automatic pair(input logic [15:0] a, input logic [15:0] b, input logic sg);
        drive(a, 1'b0, sg);
        drive(b, 1'b0, sg);
    endtask

    logic [31:0] drain_exp [4];

    initial begin
        rst                = 1'b1;
        bus.data_in        = '0;
        bus.data_in_parity = 1'b0;
        bus.data_in_valid  = 1'b0;
        bus.signed_mode    = 1'b0;
        bus.data_out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        chk("rst_count", 32'(bus.fifo_count), 0);
        chk("rst_busy",  32'(bus.busy_out), 0);
        chk("rst_valid", 32'(bus.data_out_valid), 0);
        chk("rst_data",  bus.data_out, 0);
        chk("rst_par",   32'(bus.data_out_parity), 0);
        chk("rst_perr",  32'(bus.data_in_parity_error), 0);

        // max positive squared, signed
        pair(16'h7FFF, 16'h7FFF, 1'b1);
        chk("sq_count_after_b", 32'(bus.fifo_count), 1);
        chk("sq_valid_after_b", 32'(bus.data_out_valid), 0);
        @(negedge clk);
        chk("sq_valid", 32'(bus.data_out_valid), 1);
        chk("sq_data",  bus.data_out, 32'h3FFF0001);
        chk("sq_par",   32'(bus.data_out_parity), 1);
        @(negedge clk);
        chk("sq_valid_drop", 32'(bus.data_out_valid), 0);

        pair(16'hFFFF, 16'h0002, 1'b1);
        @(negedge clk);
        chk("neg_signed_data", bus.data_out, 32'hFFFFFFFE);
        chk("neg_signed_par",  32'(bus.data_out_parity), 1);
        pair(16'hFFFF, 16'h0002, 1'b0);
        @(negedge clk);
        chk("unsigned_data", bus.data_out, 32'h0001FFFE);
        chk("unsigned_par",  32'(bus.data_out_parity), 0);
        @(negedge clk);

        // bad parity on A discards the pair
        drive(16'h0003, 1'b1, 1'b0);
        drive(16'h0001, 1'b0, 1'b0);
        chk("perr_pulse", 32'(bus.data_in_parity_error), 1);
        chk("perr_count", 32'(bus.fifo_count), 0);
        @(negedge clk);
        chk("perr_clear", 32'(bus.data_in_parity_error), 0);
        chk("perr_no_out", 32'(bus.data_out_valid), 0);

        // back-pressure: fill output register plus FIFO
        bus.data_out_ready = 1'b0;
        pair(16'd1, 16'd1, 1'b0);
        pair(16'd2, 16'd3, 1'b0);
        pair(16'd4, 16'd5, 1'b0);
        pair(16'd6, 16'd7, 1'b0);
        pair(16'd8, 16'd9, 1'b0);
        chk("full_busy",  32'(bus.busy_out), 1);
        chk("full_count", 32'(bus.fifo_count), 4);
        chk("full_valid", 32'(bus.data_out_valid), 1);
        chk("full_data",  bus.data_out, 32'd1);
        pair(16'd10, 16'd11, 1'b0);
        chk("ignored_count", 32'(bus.fifo_count), 4);
        chk("hold_data",     bus.data_out, 32'd1);

        drain_exp = '{32'd6, 32'h14, 32'h2A, 32'h48};
        bus.data_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("drain_valid", 32'(bus.data_out_valid), 1);
            chk("drain_data",  bus.data_out, drain_exp[i]);
        end
        chk("drain_busy", 32'(bus.busy_out), 0);
        @(negedge clk);
        chk("drain_done_valid", 32'(bus.data_out_valid), 0);
        chk("drain_done_count", 32'(bus.fifo_count), 0);

        // reset between A and B
        drive(16'h1234, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_count", 32'(bus.fifo_count), 0);
        chk("midrst_valid", 32'(bus.data_out_valid), 0);
        pair(16'h0002, 16'h0003, 1'b0);
        @(negedge clk);
        chk("midrst_valid_out", 32'(bus.data_out_valid), 1);
        chk("midrst_data",      bus.data_out, 32'h00000006);

        pair(16'h0000, 16'h8000, 1'b1);
        @(negedge clk);
        chk("zero_valid", 32'(bus.data_out_valid), 1);
        chk("zero_data",  bus.data_out, 32'h00000000);
        chk("zero_par",   32'(bus.data_out_parity), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
